// File: rtl/fetch_buf_ctrl_if.sv
// fetch_buf_ctrl_if: loader, consumer and RAM-port signal bundle for fetch_buf_ctrl.
// The slave modport is the controller's view; the master modport is the surrounding logic's view.
`default_nettype none

interface fetch_buf_ctrl_if #(
  parameter int DATA_W  = 64,
  parameter int BANK_AW = 7
);
  logic                wr_valid_i;
  logic                wr_ready_o;
  logic [1:0]          wr_mask_i;
  logic                wr_last_i;
  logic [DATA_W-1:0]   wr_data_i;
  logic                rd_avail_o;
  logic                rd_start_i;
  logic                rd_en_i;
  logic                rd_valid_o;
  logic                rd_last_o;
  logic [DATA_W-1:0]   rd_data_o;
  logic [1:0]          ram_a_we_o;
  logic [BANK_AW:0]    ram_a_addr_o;
  logic [DATA_W-1:0]   ram_a_data_o;
  logic                ram_b_re_o;
  logic [BANK_AW:0]    ram_b_addr_o;
  logic [DATA_W-1:0]   ram_b_data_i;

  modport slave (
    input  wr_valid_i, wr_mask_i, wr_last_i, wr_data_i,
    input  rd_start_i, rd_en_i, ram_b_data_i,
    output wr_ready_o, rd_avail_o, rd_valid_o, rd_last_o, rd_data_o,
    output ram_a_we_o, ram_a_addr_o, ram_a_data_o, ram_b_re_o, ram_b_addr_o
  );

  modport master (
    output wr_valid_i, wr_mask_i, wr_last_i, wr_data_i,
    output rd_start_i, rd_en_i, ram_b_data_i,
    input  wr_ready_o, rd_avail_o, rd_valid_o, rd_last_o, rd_data_o,
    input  ram_a_we_o, ram_a_addr_o, ram_a_data_o, ram_b_re_o, ram_b_addr_o
  );
endinterface

`default_nettype wire

// File: rtl/fetch_buf_ctrl.sv
// ----------------------------------------------------------------------------
// Module  : fetch_buf_ctrl
// Purpose : Ping-pong bank controller for the 256x64 fetch buffer RAM; one bank
//           fills from the loader while the other drains to the consumer.
//           Define FETCH_BUF_ERR_EN to add the sticky protocol-error output err_o.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_buf_ctrl #(
  parameter int BANK_AW = 7
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  fetch_buf_ctrl_if.slave   bus
`ifdef FETCH_BUF_ERR_EN
  ,
  output      logic         err_o
`endif
);

  localparam int DEPTH = 1 << BANK_AW;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_wr_bank;
  logic                 r_rd_bank;
  logic [1:0]           r_full;
  logic [BANK_AW-1:0]   r_wr_cnt;
  logic [BANK_AW-1:0]   r_rd_cnt;
  logic [BANK_AW:0]     r_len [2];
  logic                 r_rd_valid;
  logic                 r_rd_last;

  logic                 w_wr_ready;
  logic                 w_beat;
  logic                 w_wr_close;
  logic                 w_rd_avail;
  logic                 w_issue;
  logic                 w_last_issue;
  logic                 w_release;
  logic [1:0]           w_full_nxt;

  assign w_wr_ready   = ~r_full[r_wr_bank];
  assign w_beat       = bus.wr_valid_i & w_wr_ready;
  assign w_wr_close   = w_beat & (bus.wr_last_i | (r_wr_cnt == BANK_AW'(DEPTH - 1)));
  assign w_rd_avail   = r_full[r_rd_bank] & (r_state == ST_IDLE);
  assign w_issue      = (r_state == ST_READ) & bus.rd_en_i;
  assign w_last_issue = w_issue & ({1'b0, r_rd_cnt} == (r_len[r_rd_bank] - (BANK_AW+1)'(1)));
  assign w_release    = (r_state == ST_RELEASE);

  // Writer and reader always own different banks, so set and clear never collide.
  always_comb begin
    w_full_nxt = r_full;
    if (w_release) w_full_nxt[r_rd_bank] = 1'b0;
    if (w_wr_close) w_full_nxt[r_wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_full     <= 2'b00;
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_len[0]   <= '0;
      r_len[1]   <= '0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
    end else begin
      r_full     <= w_full_nxt;
      r_rd_valid <= w_issue;
      r_rd_last  <= w_last_issue;
      if (w_beat) begin
        if (w_wr_close) begin
          r_len[r_wr_bank] <= {1'b0, r_wr_cnt} + (BANK_AW+1)'(1);
          r_wr_bank        <= ~r_wr_bank;
          r_wr_cnt         <= '0;
        end else begin
          r_wr_cnt <= r_wr_cnt + BANK_AW'(1);
        end
      end
      case (r_state)
        ST_IDLE: begin
          if (bus.rd_start_i && w_rd_avail) r_state <= ST_READ;
        end
        ST_READ: begin
          if (w_issue) begin
            r_rd_cnt <= r_rd_cnt + BANK_AW'(1);
            if (w_last_issue) r_state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          r_rd_bank <= ~r_rd_bank;
          r_rd_cnt  <= '0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef FETCH_BUF_ERR_EN
  logic r_err;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if ((bus.wr_valid_i && !w_wr_ready) ||
                 (bus.rd_start_i && !w_rd_avail && (r_state == ST_IDLE))) begin
      r_err <= 1'b1;
    end
  end
  assign err_o = r_err;
`endif

  assign bus.wr_ready_o   = w_wr_ready;
  assign bus.ram_a_we_o   = w_beat ? bus.wr_mask_i : 2'b00;
  assign bus.ram_a_addr_o = {r_wr_bank, r_wr_cnt};
  assign bus.ram_a_data_o = bus.wr_data_i;
  assign bus.rd_avail_o   = w_rd_avail;
  assign bus.ram_b_re_o   = w_issue;
  assign bus.ram_b_addr_o = {r_rd_bank, r_rd_cnt};
  assign bus.rd_valid_o   = r_rd_valid;
  assign bus.rd_last_o    = r_rd_last;
  assign bus.rd_data_o    = bus.ram_b_data_i;

endmodule

`default_nettype wire

// File: tb/tb_fetch_buf_ctrl.sv
// tb_fetch_buf_ctrl: table-driven vectors plus directed fill/drain/reset sequences,
// with a behavioural 2-port RAM attached to the controller's RAM ports.
`default_nettype none

module tb_fetch_buf_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_buf_ctrl_if #(.DATA_W(64), .BANK_AW(7)) bus ();

`ifdef FETCH_BUF_ERR_EN
  logic err;
`endif

  fetch_buf_ctrl #(.BANK_AW(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FETCH_BUF_ERR_EN
    ,
    .err_o (err)
`endif
  );

  logic [63:0] ram [256];
  logic [63:0] ram_q = '0;
  always @(posedge clk) begin
    if (bus.ram_a_we_o[0]) ram[bus.ram_a_addr_o][31:0]  <= bus.ram_a_data_o[31:0];
    if (bus.ram_a_we_o[1]) ram[bus.ram_a_addr_o][63:32] <= bus.ram_a_data_o[63:32];
    if (bus.ram_b_re_o)    ram_q <= ram[bus.ram_b_addr_o];
  end
  assign bus.ram_b_data_i = ram_q;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic wv, input logic [1:0] wm, input logic wl, input logic [63:0] wd,
                     input logic rs, input logic en);
    bus.wr_valid_i = wv;
    bus.wr_mask_i  = wm;
    bus.wr_last_i  = wl;
    bus.wr_data_i  = wd;
    bus.rd_start_i = rs;
    bus.rd_en_i    = en;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drv(0, 2'b00, 0, '0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        wv;
    logic [1:0]  wm;
    logic        wl;
    logic [63:0] wd;
    logic        rs;
    logic        en;
    logic        e_rdy;
    logic [1:0]  e_we;
    logic [7:0]  e_aaddr;
    logic        e_re;
    logic        e_bchk;
    logic [7:0]  e_baddr;
    logic        e_avail;
    logic        e_valid;
    logic        e_last;
    logic [63:0] e_data;
  } vec_t;

  function automatic vec_t mk(
    input logic wv, input logic [1:0] wm, input logic wl, input logic [63:0] wd,
    input logic rs, input logic en,
    input logic e_rdy, input logic [1:0] e_we, input logic [7:0] e_aaddr,
    input logic e_re, input logic e_bchk, input logic [7:0] e_baddr,
    input logic e_avail, input logic e_valid, input logic e_last, input logic [63:0] e_data);
    vec_t v;
    v.wv = wv; v.wm = wm; v.wl = wl; v.wd = wd; v.rs = rs; v.en = en;
    v.e_rdy = e_rdy; v.e_we = e_we; v.e_aaddr = e_aaddr;
    v.e_re = e_re; v.e_bchk = e_bchk; v.e_baddr = e_baddr;
    v.e_avail = e_avail; v.e_valid = e_valid; v.e_last = e_last; v.e_data = e_data;
    return v;
  endfunction

  // Drain one full bank of length len; returns on the cycle rd_last_o is seen.
  task automatic drain(input int len, input int base_addr, input int base_data, input bit toggle,
                       input string tag);
    int  n_iss;
    int  n_rx;
    bit  seen;
    logic en;
    n_iss = 0;
    n_rx  = 0;
    seen  = 0;
    @(negedge clk);
    drv(0, 2'b00, 0, '0, 1, 0);
    #2;
    chk({tag, " avail before start"}, 64'(bus.rd_avail_o), 64'd1);
    for (int c = 0; c < 600 && !seen; c++) begin
      @(negedge clk);
      en = toggle ? logic'(c % 2 == 0) : 1'b1;
      drv(0, 2'b00, 0, '0, 0, en);
      #2;
      if (en && n_iss < len) begin
        chk({tag, " re"}, 64'(bus.ram_b_re_o), 64'd1);
        chk({tag, " issue addr"}, 64'(bus.ram_b_addr_o), 64'(base_addr + n_iss));
        n_iss++;
      end else begin
        chk({tag, " re idle"}, 64'(bus.ram_b_re_o), 64'd0);
        if (n_iss < len)
          chk({tag, " stall addr hold"}, 64'(bus.ram_b_addr_o), 64'(base_addr + n_iss));
      end
      if (bus.rd_valid_o) begin
        chk({tag, " data"}, bus.rd_data_o, 64'(base_data + n_rx));
        chk({tag, " last"}, 64'(bus.rd_last_o), 64'(n_rx == len - 1));
        if (n_rx == len - 1) seen = 1;
        n_rx++;
      end
    end
    chk({tag, " words received"}, 64'(n_rx), 64'(len));
  endtask

  vec_t vt [14];

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = '0;
    drv(0, 2'b00, 0, '0, 0, 0);

    vt[0]  = mk(0, 2'b00, 0, 64'h0,                 0, 0, 1, 2'b00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 64'h0);
    vt[1]  = mk(1, 2'b01, 0, 64'h1111111122222222,  0, 0, 1, 2'b01, 8'h00, 0, 0, 8'h00, 0, 0, 0, 64'h0);
    vt[2]  = mk(1, 2'b10, 0, 64'h3333333344444444,  0, 0, 1, 2'b10, 8'h01, 0, 0, 8'h00, 0, 0, 0, 64'h0);
    vt[3]  = mk(1, 2'b00, 0, 64'h5555555555555555,  0, 0, 1, 2'b00, 8'h02, 0, 0, 8'h00, 0, 0, 0, 64'h0);
    vt[4]  = mk(1, 2'b11, 1, 64'h6666666677777777,  0, 0, 1, 2'b11, 8'h03, 0, 0, 8'h00, 0, 0, 0, 64'h0);
    vt[5]  = mk(0, 2'b00, 0, 64'h0,                 0, 0, 1, 2'b00, 8'h00, 0, 0, 8'h00, 1, 0, 0, 64'h0);
    vt[6]  = mk(0, 2'b00, 0, 64'h0,                 1, 0, 1, 2'b00, 8'h00, 0, 0, 8'h00, 1, 0, 0, 64'h0);
    vt[7]  = mk(0, 2'b00, 0, 64'h0,                 0, 1, 1, 2'b00, 8'h00, 1, 1, 8'h00, 0, 0, 0, 64'h0);
    vt[8]  = mk(0, 2'b00, 0, 64'h0,                 0, 0, 1, 2'b00, 8'h00, 0, 1, 8'h01, 0, 1, 0, 64'h0000000022222222);
    vt[9]  = mk(0, 2'b00, 0, 64'h0,                 0, 1, 1, 2'b00, 8'h00, 1, 1, 8'h01, 0, 0, 0, 64'h0);
    vt[10] = mk(1, 2'b11, 0, 64'h000000000000ABCD,  0, 1, 1, 2'b11, 8'h80, 1, 1, 8'h02, 0, 1, 0, 64'h3333333300000000);
    vt[11] = mk(0, 2'b00, 0, 64'h0,                 0, 1, 1, 2'b00, 8'h00, 1, 1, 8'h03, 0, 1, 0, 64'h0);
    vt[12] = mk(0, 2'b00, 0, 64'h0,                 1, 1, 1, 2'b00, 8'h00, 0, 0, 8'h00, 0, 1, 1, 64'h6666666677777777);
    vt[13] = mk(0, 2'b00, 0, 64'h0,                 0, 0, 1, 2'b00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 64'h0);

    do_reset();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drv(vt[i].wv, vt[i].wm, vt[i].wl, vt[i].wd, vt[i].rs, vt[i].en);
      #2;
      chk($sformatf("v%0d wr_ready", i), 64'(bus.wr_ready_o), 64'(vt[i].e_rdy));
      chk($sformatf("v%0d ram_a_we", i), 64'(bus.ram_a_we_o), 64'(vt[i].e_we));
      if (vt[i].wv) chk($sformatf("v%0d ram_a_addr", i), 64'(bus.ram_a_addr_o), 64'(vt[i].e_aaddr));
      chk($sformatf("v%0d ram_b_re", i), 64'(bus.ram_b_re_o), 64'(vt[i].e_re));
      if (vt[i].e_bchk) chk($sformatf("v%0d ram_b_addr", i), 64'(bus.ram_b_addr_o), 64'(vt[i].e_baddr));
      chk($sformatf("v%0d rd_avail", i), 64'(bus.rd_avail_o), 64'(vt[i].e_avail));
      chk($sformatf("v%0d rd_valid", i), 64'(bus.rd_valid_o), 64'(vt[i].e_valid));
      chk($sformatf("v%0d rd_last", i), 64'(bus.rd_last_o), 64'(vt[i].e_last));
      if (vt[i].e_valid) chk($sformatf("v%0d rd_data", i), bus.rd_data_o, vt[i].e_data);
    end

    // Fill both banks completely, then confirm the writer is blocked.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      drv(1, 2'b11, 0, (i < 128) ? 64'(i) : 64'(1000 + i - 128), 0, 0);
      #2;
      chk("fill wr_ready", 64'(bus.wr_ready_o), 64'd1);
      chk("fill ram_a_addr", 64'(bus.ram_a_addr_o), 64'(i));
      if (i == 128) chk("avail after bank0 full", 64'(bus.rd_avail_o), 64'd1);
    end
    @(negedge clk);
    drv(1, 2'b11, 0, 64'hDEAD, 0, 0);
    #2;
    chk("both full wr_ready", 64'(bus.wr_ready_o), 64'd0);
    chk("both full ram_a_we", 64'(bus.ram_a_we_o), 64'd0);
`ifdef FETCH_BUF_ERR_EN
    @(negedge clk);
    drv(0, 2'b00, 0, '0, 0, 0);
    #2;
    chk("err after blocked beat", 64'(err), 64'd1);
`endif

    drain(128, 0, 0, 0, "bank0");
    chk("wr_ready during release", 64'(bus.wr_ready_o), 64'd0);
    @(negedge clk);
    drv(1, 2'b11, 0, 64'h100, 0, 0);
    #2;
    chk("wr_ready after release", 64'(bus.wr_ready_o), 64'd1);
    chk("resume ram_a_we", 64'(bus.ram_a_we_o), 64'd3);
    chk("resume ram_a_addr", 64'(bus.ram_a_addr_o), 64'd0);
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      drv(1, 2'b11, logic'(i == 4), 64'(256 + i), 0, 0);
      #2;
      chk("short ram_a_addr", 64'(bus.ram_a_addr_o), 64'(i));
    end

    drain(128, 128, 1000, 1, "bank1 toggled");
    drain(5, 0, 256, 0, "short");
    @(negedge clk);
    drv(0, 2'b00, 0, '0, 0, 0);
    #2;
    chk("empty rd_avail", 64'(bus.rd_avail_o), 64'd0);
    chk("empty wr_ready", 64'(bus.wr_ready_o), 64'd1);

    // Reset in the middle of a drain.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drv(1, 2'b11, logic'(i == 2), 64'(i), 0, 0);
    end
    @(negedge clk);
    drv(0, 2'b00, 0, '0, 1, 0);
    @(negedge clk);
    drv(0, 2'b00, 0, '0, 0, 1);
    #2;
    chk("pre-reset re", 64'(bus.ram_b_re_o), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    drv(0, 2'b00, 0, '0, 0, 1);
    @(negedge clk);
    #2;
    chk("reset rd_valid", 64'(bus.rd_valid_o), 64'd0);
    chk("reset rd_avail", 64'(bus.rd_avail_o), 64'd0);
    chk("reset wr_ready", 64'(bus.wr_ready_o), 64'd1);
    chk("reset ram_b_re", 64'(bus.ram_b_re_o), 64'd0);
`ifdef FETCH_BUF_ERR_EN
    chk("reset err", 64'(err), 64'd0);
`endif
    rst_n = 1'b1;
    drv(0, 2'b00, 0, '0, 0, 0);
    @(negedge clk);
    #2;
    chk("post-reset ram_a_addr", 64'(bus.ram_a_addr_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
